// File: rtl/bus_pkg.sv
// Shared definitions for the system bus slaves.
//   bus_state_e        : slave transaction FSM states
//   BUS_ADDR_W/DATA_W  : default bus address / data widths
//   BUS_READ/BUS_WRITE : encodings of bus_we
package bus_pkg;

    localparam int BUS_ADDR_W = 16;
    localparam int BUS_DATA_W = 8;

    localparam logic BUS_READ  = 1'b0;
    localparam logic BUS_WRITE = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2,
        S_HOLD = 2'd3
    } bus_state_e;

endpackage

// File: rtl/bus_mem_array.sv
// Single-port synchronous RAM, 2^DEPTH_W x DATA_W, block-RAM style.
//   clk_i    : clock
//   rst_i    : synchronous reset of the read register only (contents are not reset)
//   we_i     : write wdata_i to addr_i at the rising edge
//   re_i     : load mem[addr_i] into the read register at the rising edge
//   addr_i   : word index
//   wdata_i  : write data
//   rdata_o  : registered read data, held while re_i is low
module bus_mem_array #(
    parameter int DEPTH_W = 8,
    parameter int DATA_W  = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               we_i,
    input  logic               re_i,
    input  logic [DEPTH_W-1:0] addr_i,
    input  logic [DATA_W-1:0]  wdata_i,
    output logic [DATA_W-1:0]  rdata_o
);

    logic [DATA_W-1:0] mem_q [2**DEPTH_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)     rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_mem_slave.sv
// Word-addressed memory slave on the system bus with programmable wait states.
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   bus_req    : request, held until bus_ack
//   bus_we     : 1 = write, 0 = read
//   bus_addr   : word address; upper bits select this slave's window
//   bus_wdata  : write data
//   bus_rdata  : registered read data, valid in the ack cycle and held afterwards
//   bus_ack    : one-cycle completion pulse
//   last_wdata : low byte of the last committed write (debug LEDs)
module bus_mem_slave
    import bus_pkg::*;
#(
    parameter int                ADDR_W      = BUS_ADDR_W,
    parameter int                DATA_W      = BUS_DATA_W,
    parameter int                DEPTH_W     = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bus_req,
    input  logic              bus_we,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [DATA_W-1:0] bus_wdata,
    output logic [DATA_W-1:0] bus_rdata,
    output logic              bus_ack,
    output logic [7:0]        last_wdata
);

    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    bus_state_e         state_q;
    logic [3:0]         cnt_q;
    logic               we_q;
    logic [DEPTH_W-1:0] idx_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               ack_q;
    logic [7:0]         last_wdata_q;

    logic               hit;
    logic               capture;
    logic               enter_ack;
    logic               txn_we;
    logic [DEPTH_W-1:0] ram_idx;
    logic               ram_re;
    logic               ram_we;

    assign hit     = (bus_addr[ADDR_W-1:DEPTH_W] == BASE_ADDR[ADDR_W-1:DEPTH_W]);
    assign capture = (state_q == S_IDLE) && bus_req && hit;

    // With zero wait states the ACK state is entered straight from the capture edge.
    assign enter_ack = (capture && (WAIT_STATES == 0)) ||
                       ((state_q == S_WAIT) && bus_req && (cnt_q == 4'd0));

    // The read must be launched at the edge entering ACK; in the zero-wait case
    // that is the capture edge itself, so the live bus fields are used in IDLE.
    assign txn_we  = (state_q == S_IDLE) ? bus_we : we_q;
    assign ram_idx = (state_q == S_IDLE) ? bus_addr[DEPTH_W-1:0] : idx_q;
    assign ram_re  = enter_ack && (txn_we == BUS_READ) && !rst;
    assign ram_we  = (state_q == S_ACK) && (we_q == BUS_WRITE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            we_q         <= BUS_READ;
            idx_q        <= '0;
            wdata_q      <= '0;
            ack_q        <= 1'b0;
            last_wdata_q <= 8'h00;
        end else begin
            ack_q <= enter_ack;
            case (state_q)
                S_IDLE: begin
                    if (capture) begin
                        we_q    <= bus_we;
                        idx_q   <= bus_addr[DEPTH_W-1:0];
                        wdata_q <= bus_wdata;
                        cnt_q   <= WAIT_LOAD;
                        state_q <= (WAIT_STATES == 0) ? S_ACK : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!bus_req) begin
                        // master gave up: drop the transaction silently
                        cnt_q   <= 4'd0;
                        state_q <= S_IDLE;
                    end else if (cnt_q == 4'd0) begin
                        state_q <= S_ACK;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_ACK: begin
                    if (we_q == BUS_WRITE) last_wdata_q <= 8'(wdata_q);
                    state_q <= S_HOLD;
                end
                S_HOLD: begin
                    // a request still held from the finished transaction must not restart
                    if (!bus_req) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    bus_mem_array #(
        .DEPTH_W (DEPTH_W),
        .DATA_W  (DATA_W)
    ) u_mem (
        .clk_i   (clk),
        .rst_i   (rst),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (ram_idx),
        .wdata_i (wdata_q),
        .rdata_o (bus_rdata)
    );

    assign bus_ack    = ack_q;
    assign last_wdata = last_wdata_q;

endmodule
